// File: rtl/ip_dec_pkg.sv
// Shared definitions for the parametrised IPv4 header decoder: FSM state
// encoding, error codes, the IPv4 version constant and the ones'-complement
// fold used by the header checksum.
package ip_dec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_OPT  = 3'd2,
    ST_PAY  = 3'd3,
    ST_SKIP = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_VERSION = 3'd1;
  localparam logic [2:0] ERR_IHL     = 3'd2;
  localparam logic [2:0] ERR_CHKSUM  = 3'd3;
  localparam logic [2:0] ERR_LENGTH  = 3'd4;
  localparam logic [2:0] ERR_TTL     = 3'd5;
  localparam logic [2:0] ERR_PROTO   = 3'd6;
  localparam logic [2:0] ERR_TRUNC   = 3'd7;

  localparam logic [3:0] IPV4_VERSION = 4'd4;

  // Fold an 18-bit partial sum into 16 bits with end-around carry.
  // The second add cannot overflow: a carry out of the first add leaves
  // at most 16'd2 in the low half.
  function automatic logic [15:0] ones_fold16(input logic [17:0] sum);
    logic [16:0] t;
    t = {1'b0, sum[15:0]} + {15'd0, sum[17:16]};
    return t[15:0] + {15'd0, t[16]};
  endfunction

endpackage

// File: rtl/ip_chksum16.sv
// Ones'-complement header checksum accumulator. sum_o already includes the
// word presented this cycle, so the caller can compare it on the last
// header word without waiting an extra cycle. clr_i restarts the sum with
// the current word.
module ip_chksum16
  import ip_dec_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [31:0] word_i,
  output logic [15:0] sum_o
);

  logic [15:0] acc_q;
  logic [15:0] base_s;

  assign base_s = clr_i ? 16'd0 : acc_q;
  assign sum_o  = ones_fold16({2'b00, base_s} + {2'b00, word_i[31:16]} + {2'b00, word_i[15:0]});

  // Accumulator register: take the folded sum on each added word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= 16'd0;
    end else if (add_i) begin
      acc_q <= sum_o;
    end else if (clr_i) begin
      acc_q <= 16'd0;
    end
  end

endmodule

// File: rtl/ip_decoder_param.sv
// Parametrised IPv4 header decoder. Latches header fields, skips option
// words, validates the header and forwards only payload bytes with byte
// enables, dropping link-layer padding.
// Optional build macro: IP_DEC_CHKSUM_EN enables header checksum checking;
// without it the checksum field is ignored and error code 3 never occurs.
module ip_decoder_param
  import ip_dec_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 1500,
  parameter logic [7:0]  PROTO_FILTER = 8'd0,
  parameter logic [7:0]  MIN_TTL      = 8'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        start,
  output logic [3:0]  version,
  output logic [3:0]  IHL,
  output logic [7:0]  type_of_ser,
  output logic [7:0]  time_to_live,
  output logic [7:0]  protocol,
  output logic [15:0] total_length,
  output logic [15:0] identification,
  output logic [2:0]  flag,
  output logic [12:0] frag_offset,
  output logic [31:0] src_ip,
  output logic [31:0] dest_ip,
  output logic [15:0] len_out,
  output logic [31:0] data_out,
  output logic [3:0]  keep,
  output logic        wr_en,
  output logic        ok,
  output logic        fin,
  output logic [2:0]  err_code
);

  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] rem_q, rem_d;
  logic [3:0]  version_q, version_d, ihl_q, ihl_d;
  logic [7:0]  tos_q, tos_d, ttl_q, ttl_d, proto_q, proto_d;
  logic [15:0] tl_q, tl_d, ident_q, ident_d, len_q, len_d;
  logic [2:0]  flag_q, flag_d;
  logic [12:0] frag_q, frag_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, dout_q, dout_d;
  logic [3:0]  keep_q, keep_d;
  logic        wr_q, wr_d, ok_q, ok_d, fin_q, fin_d;
  logic [2:0]  err_q, err_d;

  logic [15:0] hdr_bytes_s;
  logic [15:0] pay_len_s;
  logic        last_hdr_s;
  logic        chk_bad_s;
  logic [2:0]  err_s;
  logic [3:0]  keep_last_s;
  logic [31:0] mask_s;

`ifdef IP_DEC_CHKSUM_EN
  logic [15:0] chk_sum_s;
  logic        chk_clr_s;
  logic        chk_add_s;

  assign chk_clr_s = (state_q == ST_IDLE) && start;
  assign chk_add_s = start && ((state_q == ST_IDLE) || (state_q == ST_HDR) || (state_q == ST_OPT));

  ip_chksum16 u_chksum (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (chk_clr_s),
    .add_i  (chk_add_s),
    .word_i (data),
    .sum_o  (chk_sum_s)
  );

  assign chk_bad_s = (chk_sum_s != 16'hFFFF);
`else
  assign chk_bad_s = 1'b0;
`endif

  assign hdr_bytes_s = {10'd0, ihl_q, 2'b00};
  assign pay_len_s   = tl_q - hdr_bytes_s;
  // Header ends on word 4 unless options follow; option words run to IHL-1.
  assign last_hdr_s  = (state_q == ST_HDR) ? ((idx_q == 4'd4) && (ihl_q <= 4'd5))
                                           : (idx_q == (ihl_q - 4'd1));
  assign mask_s      = {{8{keep_last_s[3]}}, {8{keep_last_s[2]}},
                        {8{keep_last_s[1]}}, {8{keep_last_s[0]}}};

  // Header check result, highest-priority failure first.
  always_comb begin
    if (version_q != IPV4_VERSION) begin
      err_s = ERR_VERSION;
    end else if (ihl_q < 4'd5) begin
      err_s = ERR_IHL;
    end else if (chk_bad_s) begin
      err_s = ERR_CHKSUM;
    end else if ((tl_q < hdr_bytes_s) || (tl_q > MAX_LEN_C)) begin
      err_s = ERR_LENGTH;
    end else if (ttl_q < MIN_TTL) begin
      err_s = ERR_TTL;
    end else if ((PROTO_FILTER != 8'd0) && (proto_q != PROTO_FILTER)) begin
      err_s = ERR_PROTO;
    end else begin
      err_s = ERR_NONE;
    end
  end

  // Byte enables for the final payload word from the remaining byte count.
  always_comb begin
    case (rem_q[1:0])
      2'd1:    keep_last_s = 4'b1000;
      2'd2:    keep_last_s = 4'b1100;
      2'd3:    keep_last_s = 4'b1110;
      default: keep_last_s = 4'b1111;
    endcase
  end

  // Next-state and output logic of the packet FSM.
  always_comb begin
    state_d = state_q;   idx_d   = idx_q;   rem_d  = rem_q;
    version_d = version_q; ihl_d = ihl_q;   tos_d  = tos_q;
    ttl_d   = ttl_q;     proto_d = proto_q; tl_d   = tl_q;
    ident_d = ident_q;   flag_d  = flag_q;  frag_d = frag_q;
    src_d   = src_q;     dst_d   = dst_q;   len_d  = len_q;
    ok_d    = ok_q;      err_d   = err_q;
    dout_d  = 32'd0;     keep_d  = 4'd0;    wr_d   = 1'b0;  fin_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          version_d = data[31:28];
          ihl_d     = data[27:24];
          tos_d     = data[23:16];
          tl_d      = data[15:0];
          ok_d      = 1'b0;
          err_d     = ERR_NONE;
          idx_d     = 4'd1;
          state_d   = ST_HDR;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_HDR, ST_OPT: begin
        if (!start) begin
          err_d   = ERR_TRUNC;
          ok_d    = 1'b0;
          fin_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (state_q == ST_HDR) begin
            case (idx_q)
              4'd1:    begin ident_d = data[31:16]; flag_d = data[15:13]; frag_d = data[12:0]; end
              4'd2:    begin ttl_d = data[31:24]; proto_d = data[23:16]; end
              4'd3:    src_d = data;
              4'd4:    dst_d = data;
              default: src_d = src_q;
            endcase
          end else begin
            idx_d = idx_q;
          end
          if (last_hdr_s) begin
            len_d = pay_len_s;
            rem_d = pay_len_s;
            err_d = err_s;
            if (err_s != ERR_NONE) begin
              ok_d    = 1'b0;
              state_d = ST_ERR;
            end else if (pay_len_s == 16'd0) begin
              ok_d    = 1'b1;
              fin_d   = 1'b1;
              state_d = ST_SKIP;
            end else begin
              ok_d    = 1'b1;
              state_d = ST_PAY;
            end
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = (idx_q >= 4'd4) ? ST_OPT : state_q;
          end
        end
      end
      ST_PAY: begin
        if (!start) begin
          err_d   = ERR_TRUNC;
          ok_d    = 1'b0;
          fin_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (rem_q <= 16'd4) begin
          wr_d    = 1'b1;
          keep_d  = keep_last_s;
          dout_d  = data & mask_s;
          fin_d   = 1'b1;
          rem_d   = 16'd0;
          state_d = ST_SKIP;
        end else begin
          wr_d    = 1'b1;
          keep_d  = 4'hF;
          dout_d  = data;
          rem_d   = rem_q - 16'd4;
        end
      end
      ST_SKIP: begin
        state_d = start ? ST_SKIP : ST_IDLE;
      end
      ST_ERR: begin
        if (!start) begin
          fin_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE; idx_q <= 4'd0;  rem_q <= 16'd0;
      version_q <= 4'd0;  ihl_q <= 4'd0;  tos_q <= 8'd0;
      ttl_q <= 8'd0;      proto_q <= 8'd0; tl_q <= 16'd0;
      ident_q <= 16'd0;   flag_q <= 3'd0; frag_q <= 13'd0;
      src_q <= 32'd0;     dst_q <= 32'd0; len_q <= 16'd0;
      dout_q <= 32'd0;    keep_q <= 4'd0; wr_q <= 1'b0;
      ok_q <= 1'b0;       fin_q <= 1'b0;  err_q <= 3'd0;
    end else begin
      state_q <= state_d; idx_q <= idx_d; rem_q <= rem_d;
      version_q <= version_d; ihl_q <= ihl_d; tos_q <= tos_d;
      ttl_q <= ttl_d;     proto_q <= proto_d; tl_q <= tl_d;
      ident_q <= ident_d; flag_q <= flag_d; frag_q <= frag_d;
      src_q <= src_d;     dst_q <= dst_d; len_q <= len_d;
      dout_q <= dout_d;   keep_q <= keep_d; wr_q <= wr_d;
      ok_q <= ok_d;       fin_q <= fin_d; err_q <= err_d;
    end
  end

  assign version        = version_q;
  assign IHL            = ihl_q;
  assign type_of_ser    = tos_q;
  assign time_to_live   = ttl_q;
  assign protocol       = proto_q;
  assign total_length   = tl_q;
  assign identification = ident_q;
  assign flag           = flag_q;
  assign frag_offset    = frag_q;
  assign src_ip         = src_q;
  assign dest_ip        = dst_q;
  assign len_out        = len_q;
  assign data_out       = dout_q;
  assign keep           = keep_q;
  assign wr_en          = wr_q;
  assign ok             = ok_q;
  assign fin            = fin_q;
  assign err_code       = err_q;

endmodule

// File: tb/tb_ip_decoder_param.sv
// Directed self-checking bench for ip_decoder_param (default parameters).
`timescale 1ns/1ps
module tb_ip_decoder_param;

  logic        clk, reset, start;
  logic [31:0] data;
  logic [3:0]  version, IHL, keep;
  logic [7:0]  type_of_ser, time_to_live, protocol;
  logic [15:0] total_length, identification, len_out;
  logic [2:0]  flag, err_code;
  logic [12:0] frag_offset;
  logic [31:0] src_ip, dest_ip, data_out;
  logic        wr_en, ok, fin;

  ip_decoder_param dut (
    .clk(clk), .reset(reset), .data(data), .start(start),
    .version(version), .IHL(IHL), .type_of_ser(type_of_ser),
    .time_to_live(time_to_live), .protocol(protocol),
    .total_length(total_length), .identification(identification),
    .flag(flag), .frag_offset(frag_offset), .src_ip(src_ip), .dest_ip(dest_ip),
    .len_out(len_out), .data_out(data_out), .keep(keep), .wr_en(wr_en),
    .ok(ok), .fin(fin), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  logic [31:0] wq_d[$];
  logic [3:0]  wq_k[$];
  logic        wq_f[$];
  int          fin_cnt = 0;
  int          fin_cyc = 0;
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_d.push_back(data_out);
      wq_k.push_back(keep);
      wq_f.push_back(fin);
    end
    if (fin === 1'b1) begin
      fin_cnt <= fin_cnt + 1;
      fin_cyc <= cyc;
    end
  end

  logic all_or;
  assign all_or = |{version, IHL, type_of_ser, time_to_live, protocol, total_length,
                    identification, flag, frag_offset, src_ip, dest_ip, len_out,
                    data_out, keep, wr_en, ok, fin, err_code};

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] pkt [0:511];
  int          hdr_n, w0, f0, fall_cyc;
  logic [31:0] e_d [0:3];
  logic [3:0]  e_k [0:3];
  logic        e_f [0:3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] csum(input int n);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < n; i++) s = s + {16'd0, pkt[i][31:16]} + {16'd0, pkt[i][15:0]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic build(input logic [3:0] ver, input logic [3:0] ihl,
                       input logic [15:0] tl, input logic [7:0] ttl);
    int hn;
    hn = (ihl > 4'd5) ? int'(ihl) : 5;
    pkt[0] = {ver, ihl, 8'h00, tl};
    pkt[1] = 32'h1234_4000;
    pkt[2] = {ttl, 8'h11, 16'h0000};
    pkt[3] = 32'hC0A8_0001;
    pkt[4] = 32'hC0A8_0002;
    for (int i = 5; i < hn; i++) pkt[i] = 32'd0;
    pkt[2][15:0] = csum(hn);
    hdr_n = hn;
  endtask

  task automatic add_hello();
    pkt[hdr_n]     = 32'h4865_6C6C;
    pkt[hdr_n + 1] = 32'h6F20_576F;
    pkt[hdr_n + 2] = 32'h726C_64AA;
    e_d[0] = 32'h4865_6C6C; e_k[0] = 4'hF;    e_f[0] = 1'b0;
    e_d[1] = 32'h6F20_576F; e_k[1] = 4'hF;    e_f[1] = 1'b0;
    e_d[2] = 32'h726C_6400; e_k[2] = 4'b1110; e_f[2] = 1'b1;
  endtask

  task automatic send(input int n);
    w0 = wq_d.size();
    f0 = fin_cnt;
    for (int i = 0; i < n; i++) begin
      data = pkt[i]; start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0; data = 32'd0; fall_cyc = cyc;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_pkt(input string tag, input int nw, input logic e_ok,
                         input logic [2:0] e_err, input logic [15:0] e_len);
    int got;
    got = wq_d.size() - w0;
    chk({tag, "_nwr"}, 64'(got), 64'(nw));
    for (int i = 0; i < nw && i < got; i++)
      chk({tag, "_wr"}, {wq_f[w0 + i], wq_k[w0 + i], wq_d[w0 + i]}, {e_f[i], e_k[i], e_d[i]});
    chk({tag, "_nfin"}, 64'(fin_cnt - f0), 64'd1);
    chk({tag, "_status"}, {ok, err_code, len_out}, {e_ok, e_err, e_len});
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; data = 32'd0;
    #12;
    chk("reset_outputs_zero", all_or, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_outputs_zero", all_or, 1'b0);

    // Baseline: IHL 5, 11-byte payload.
    build(4'd4, 4'd5, 16'd31, 8'h40); add_hello(); send(hdr_n + 3);
    chk_pkt("base", 3, 1'b1, 3'd0, 16'd11);
    chk("base_hdr_a", {version, IHL, type_of_ser, time_to_live, protocol, total_length},
        {4'd4, 4'd5, 8'h00, 8'h40, 8'h11, 16'd31});
    chk("base_hdr_b", {identification, flag, frag_offset}, {16'h1234, 3'b010, 13'd0});
    chk("base_ips", {src_ip, dest_ip}, {32'hC0A8_0001, 32'hC0A8_0002});

    // One option word.
    build(4'd4, 4'd6, 16'd35, 8'h40); add_hello(); send(hdr_n + 3);
    chk_pkt("opt", 3, 1'b1, 3'd0, 16'd11);
    chk("opt_ihl", IHL, 4'd6);

    // Corrupted checksum field.
    build(4'd4, 4'd5, 16'd31, 8'h40); add_hello();
    pkt[2] = pkt[2] ^ 32'd1;
    send(hdr_n + 3);
`ifdef IP_DEC_CHKSUM_EN
    chk_pkt("badck", 0, 1'b0, 3'd3, 16'd11);
    chk("badck_fin_time", 64'(fin_cyc), 64'(fall_cyc + 1));
`else
    chk_pkt("badck", 3, 1'b1, 3'd0, 16'd11);
`endif

    // Link-layer padding after an 8-byte payload.
    build(4'd4, 4'd5, 16'd28, 8'h40);
    pkt[5] = 32'h4865_6C6C; pkt[6] = 32'h6F20_576F;
    for (int i = 7; i < 11; i++) pkt[i] = 32'hDEAD_BEEF;
    e_d[0] = 32'h4865_6C6C; e_k[0] = 4'hF; e_f[0] = 1'b0;
    e_d[1] = 32'h6F20_576F; e_k[1] = 4'hF; e_f[1] = 1'b1;
    send(11);
    chk_pkt("pad", 2, 1'b1, 3'd0, 16'd8);

    // Truncation after the first payload word.
    build(4'd4, 4'd5, 16'd31, 8'h40); add_hello(); send(hdr_n + 1);
    chk_pkt("trunc", 1, 1'b0, 3'd7, 16'd11);
    chk("trunc_fin_time", 64'(fin_cyc), 64'(fall_cyc + 1));

    // Header-only packet: no payload, fin at end of header.
    build(4'd4, 4'd5, 16'd20, 8'h40);
    pkt[5] = 32'hDEAD_BEEF; pkt[6] = 32'hDEAD_BEEF;
    send(7);
    chk_pkt("zero", 0, 1'b1, 3'd0, 16'd0);

    // Header errors, each followed by ignored payload words.
    build(4'd6, 4'd5, 16'd31, 8'h40); add_hello(); send(hdr_n + 3);
    chk_pkt("ver", 0, 1'b0, 3'd1, 16'd11);
    chk("ver_fin_time", 64'(fin_cyc), 64'(fall_cyc + 1));
    build(4'd4, 4'd4, 16'd31, 8'h40); add_hello(); send(hdr_n + 3);
    chk_pkt("ihl", 0, 1'b0, 3'd2, 16'd15);
    build(4'd4, 4'd5, 16'd1501, 8'h40); add_hello(); send(hdr_n + 3);
    chk_pkt("len", 0, 1'b0, 3'd4, 16'd1481);
    build(4'd4, 4'd5, 16'd31, 8'h00); add_hello(); send(hdr_n + 3);
    chk_pkt("ttl", 0, 1'b0, 3'd5, 16'd11);

    // Largest accepted packet.
    build(4'd4, 4'd5, 16'd1500, 8'h40);
    for (int i = 0; i < 370; i++) pkt[5 + i] = 32'hA500_0000 | 32'(i);
    send(375);
    chk("max_nwr", 64'(wq_d.size() - w0), 64'd370);
    if (wq_d.size() > w0)
      chk("max_last", {wq_f[wq_d.size() - 1], wq_k[wq_d.size() - 1], wq_d[wq_d.size() - 1]},
          {1'b1, 4'hF, pkt[374]});
    chk("max_nfin", 64'(fin_cnt - f0), 64'd1);
    chk("max_status", {ok, err_code, len_out}, {1'b1, 3'd0, 16'd1480});

    // Reset pulse in the middle of the payload.
    build(4'd4, 4'd5, 16'd31, 8'h40); add_hello();
    for (int i = 0; i < 6; i++) begin
      data = pkt[i]; start = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_mid_pay_wr", wr_en, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_async_zero", all_or, 1'b0);
    start = 1'b0; data = 32'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_after_zero", all_or, 1'b0);
    send(hdr_n + 3);
    chk_pkt("post_rst", 3, 1'b1, 3'd0, 16'd11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
